// File: rtl/glitch_filter.sv
// Per-channel glitch filter with registered edge pulses.
// A new value on sync_i must persist for FilterCycles consecutive cycles
// before level_o follows it. rise_o and fall_o pulse for one cycle, aligned
// with the level_o change.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   sync_i  : already-synchronized input level
//   level_o : filtered level
//   rise_o  : one-cycle pulse on a 0->1 change of level_o
//   fall_o  : one-cycle pulse on a 1->0 change of level_o
module glitch_filter #(
    parameter int unsigned FilterCycles = 4,
    parameter logic        ResetValue   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW    = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

    logic            level_q;
    logic [CntW-1:0] cnt_q;
    logic            rise_q;
    logic            fall_q;
    logic            differ;
    logic            expire;

    always_comb begin
        differ = 1'b0;
        expire = 1'b0;
        differ = (sync_i != level_q);
        expire = differ && (cnt_q == CntLast);
    end

    // The edge flops load from the same condition that updates level_q,
    // so each pulse lines up exactly with the level change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= ResetValue;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= expire & sync_i;
            fall_q <= expire & ~sync_i;
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                level_q <= sync_i;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cdc_sync_filter.sv
// Multi-channel synchronizer: each asynchronous input passes through a
// resettable flop chain, then a per-channel glitch filter with edge pulses.
// Channels are independent; not suitable for multi-bit buses.
//   clk_i   : the only clock
//   rst_i   : synchronous active-high reset
//   async_i : asynchronous inputs, one per channel
//   data_o  : filtered, synchronized levels
//   rise_o  : one-cycle pulse per channel on a 0->1 change of data_o
//   fall_o  : one-cycle pulse per channel on a 1->0 change of data_o
module cdc_sync_filter #(
    parameter int unsigned         SyncStages   = 2,
    parameter int unsigned         Channels     = 1,
    parameter int unsigned         FilterCycles = 4,
    parameter logic [Channels-1:0] ResetValue   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Channels-1:0] async_i,
    output logic [Channels-1:0] data_o,
    output logic [Channels-1:0] rise_o,
    output logic [Channels-1:0] fall_o
);

    if (SyncStages < 2) begin : g_bad_sync_stages
        $error("cdc_sync_filter: SyncStages must be >= 2");
    end
    if (Channels < 1) begin : g_bad_channels
        $error("cdc_sync_filter: Channels must be >= 1");
    end
    if (FilterCycles < 1) begin : g_bad_filter_cycles
        $error("cdc_sync_filter: FilterCycles must be >= 1");
    end

    // Stage 0 is the only flop fed by an asynchronous signal.
    (* ASYNC_REG = "TRUE" *) logic [Channels-1:0] sync_q [SyncStages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SyncStages; s++) begin
                sync_q[s] <= ResetValue;
            end
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned s = 1; s < SyncStages; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar c = 0; c < Channels; c++) begin : g_chan
        glitch_filter #(
            .FilterCycles (FilterCycles),
            .ResetValue   (ResetValue[c])
        ) u_filter (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .sync_i  (sync_q[SyncStages-1][c]),
            .level_o (data_o[c]),
            .rise_o  (rise_o[c]),
            .fall_o  (fall_o[c])
        );
    end

endmodule

// File: tb/tb_cdc_sync_filter.sv
module tb_cdc_sync_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default configuration: SyncStages=2, Channels=1, FilterCycles=4, ResetValue=0
    logic       rst_d   = 1'b1;
    logic [0:0] async_d = 1'b0;
    logic [0:0] data_d, rise_d, fall_d;

    // Two channels with a non-zero reset value
    logic       rst_r   = 1'b1;
    logic [1:0] async_r = 2'b01;
    logic [1:0] data_r, rise_r, fall_r;

    // Four channels, no filtering
    logic       rst_c   = 1'b1;
    logic [3:0] async_c = 4'b1001;
    logic [3:0] data_c, rise_c, fall_c;

    cdc_sync_filter u_def (
        .clk_i   (clk),
        .rst_i   (rst_d),
        .async_i (async_d),
        .data_o  (data_d),
        .rise_o  (rise_d),
        .fall_o  (fall_d)
    );

    cdc_sync_filter #(
        .Channels   (2),
        .ResetValue (2'b01)
    ) u_rv (
        .clk_i   (clk),
        .rst_i   (rst_r),
        .async_i (async_r),
        .data_o  (data_r),
        .rise_o  (rise_r),
        .fall_o  (fall_r)
    );

    cdc_sync_filter #(
        .SyncStages   (2),
        .Channels     (4),
        .FilterCycles (1)
    ) u_ch (
        .clk_i   (clk),
        .rst_i   (rst_c),
        .async_i (async_c),
        .data_o  (data_c),
        .rise_o  (rise_c),
        .fall_o  (fall_c)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (data_r !== 2'b01 || rise_r !== 2'b00 || fall_r !== 2'b00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d data=%b rise=%b fall=%b, want data=01 rise=00 fall=00",
                         i, data_r, rise_r, fall_r);
            end
            checks++;
            if (data_d !== 1'b0 || rise_d !== 1'b0 || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL reset_default cyc=%0d data=%b rise=%b fall=%b, want 0 0 0",
                         i, data_d, rise_d, fall_d);
            end
        end
        rst_d = 1'b0;
        rst_r = 1'b0;
        rst_c = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (data_r !== 2'b01 || rise_r !== 2'b00 || fall_r !== 2'b00) begin
                failures++;
                $display("FAIL reset_release cyc=%0d data=%b rise=%b fall=%b, want data=01 rise=00 fall=00",
                         i, data_r, rise_r, fall_r);
            end
            checks++;
            if (data_d !== 1'b0 || rise_d !== 1'b0 || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL reset_release_default cyc=%0d data=%b rise=%b fall=%b, want 0 0 0",
                         i, data_d, rise_d, fall_d);
            end
        end
    endtask

    // Input rises, captured at edge k = first tick; outputs change after edge k+5.
    task automatic test_latency();
        logic exp_data, exp_rise;
        async_d = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_data = (i >= 6);
            exp_rise = (i == 6);
            checks++;
            if (data_d !== exp_data || rise_d !== exp_rise || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL latency_rise tick=%0d data=%b rise=%b fall=%b, want data=%b rise=%b fall=0",
                         i, data_d, rise_d, fall_d, exp_data, exp_rise);
            end
        end
        async_d = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_data = (i < 6);
            checks++;
            if (data_d !== exp_data || rise_d !== 1'b0 || fall_d !== (i == 6)) begin
                failures++;
                $display("FAIL latency_fall tick=%0d data=%b rise=%b fall=%b, want data=%b rise=0 fall=%b",
                         i, data_d, rise_d, fall_d, exp_data, (i == 6));
            end
        end
    endtask

    task automatic test_glitch();
        logic exp_data;
        // Three-cycle pulse: filtered out completely.
        async_d = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) async_d = 1'b0;
            checks++;
            if (data_d !== 1'b0 || rise_d !== 1'b0 || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL glitch_3cyc tick=%0d data=%b rise=%b fall=%b, want 0 0 0",
                         i, data_d, rise_d, fall_d);
            end
        end
        // Four-cycle pulse: passes, rise at tick 6, fall at tick 10.
        async_d = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4) async_d = 1'b0;
            exp_data = (i >= 6) && (i <= 9);
            checks++;
            if (data_d !== exp_data || rise_d !== (i == 6) || fall_d !== (i == 10)) begin
                failures++;
                $display("FAIL glitch_4cyc tick=%0d data=%b rise=%b fall=%b, want data=%b rise=%b fall=%b",
                         i, data_d, rise_d, fall_d, exp_data, (i == 6), (i == 10));
            end
        end
    endtask

    // High 3, low 1, then high: second high captured at tick 5, rise at tick 10.
    task automatic test_count_restart();
        int rises = 0;
        async_d = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 3) async_d = 1'b0;
            if (i == 4) async_d = 1'b1;
            if (rise_d === 1'b1) rises++;
            checks++;
            if (data_d !== (i >= 10) || rise_d !== (i == 10) || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL count_restart tick=%0d data=%b rise=%b fall=%b, want data=%b rise=%b fall=0",
                         i, data_d, rise_d, fall_d, (i >= 10), (i == 10));
            end
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL count_restart_pulses got=%0d want=1", rises);
        end
        async_d = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (data_d !== 1'b0) begin
            failures++;
            $display("FAIL count_restart_return data=%b want=0", data_d);
        end
    endtask

    // Reset applied at the edge after the count reached 2; the transition then
    // needs a full latency from the first post-reset edge (tick 6) -> tick 11.
    task automatic test_mid_reset();
        async_d = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 4) rst_d = 1'b1;
            if (i == 5) rst_d = 1'b0;
            checks++;
            if (data_d !== (i >= 11) || rise_d !== (i == 11) || fall_d !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset tick=%0d data=%b rise=%b fall=%b, want data=%b rise=%b fall=0",
                         i, data_d, rise_d, fall_d, (i >= 11), (i == 11));
            end
        end
        async_d = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
    endtask

    // Bit 2 toggles every 2 cycles; data follows after 2 edges (FilterCycles=1).
    task automatic test_channel_independence();
        logic v [-3:20];
        logic [3:0] exp_data, exp_rise, exp_fall;
        for (int j = -3; j <= 20; j++) v[j] = (j >= 1) ? 1'(((j - 1) >> 1) & 1) : 1'b0;
        // v[j] = bit-2 value held across the edge of tick j
        for (int i = 1; i <= 16; i++) begin
            async_c[2] = v[i];
            tick();
            exp_data = {1'b1, v[i-2], 1'b0, 1'b1};
            exp_rise = {1'b0, v[i-2] & ~v[i-3], 2'b00};
            exp_fall = {1'b0, ~v[i-2] & v[i-3], 2'b00};
            checks++;
            if (data_c !== exp_data || rise_c !== exp_rise || fall_c !== exp_fall) begin
                failures++;
                $display("FAIL chan_indep tick=%0d data=%b rise=%b fall=%b, want data=%b rise=%b fall=%b",
                         i, data_c, rise_c, fall_c, exp_data, exp_rise, exp_fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_count_restart();
        test_mid_reset();
        test_channel_independence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_sync_filter.md
# cdc_sync_filter

Multi-channel input synchronizer with reset, per-channel glitch filter and edge-pulse outputs. Brings asynchronous single-bit signals (buttons, external strobes, status pins) into the `clk_i` domain. Each channel is synchronized through a resettable flop chain, then must stay stable for a programmable number of cycles before the filtered output changes. Registered rise/fall pulses accompany each filtered transition. Channels are independent; no cross-channel coherency is provided, so this block is not for multi-bit buses.

## Interface
Parameters:
- `SyncStages`, 2: synchronizer flops per channel; must be ≥ 2.
- `Channels`, 1: number of independent single-bit channels; must be ≥ 1.
- `FilterCycles`, 4: consecutive cycles a new synchronized value must persist before `data_o` follows; must be ≥ 1. A value of 1 means no filtering (one register stage).
- `ResetValue`, '0 (`Channels` bits): reset value of the sync chain and `data_o`, per channel.

Ports:
- `clk_i`, in, 1: the only clock. Reset is synchronous and active-high.
- `rst_i`, in, 1: synchronous, active-high reset.
- `async_i`, in, `Channels`: asynchronous inputs, one per channel.
- `data_o`, out, `Channels`: filtered, synchronized level.
- `rise_o`, out, `Channels`: one-cycle pulse on a 0→1 transition of `data_o`.
- `fall_o`, out, `Channels`: one-cycle pulse on a 1→0 transition of `data_o`.

## Operation
- Elaboration fails with `$error` if `SyncStages` < 2, `Channels` < 1 or `FilterCycles` < 1.
- Sync chain: stage 0 samples `async_i[c]`; stage n samples stage n-1. `sync[c]` is the last stage.
- Filter per channel: state `filt[c]` drives `data_o[c]`; counter `cnt[c]` has width `$clog2(FilterCycles+1)`.
  - If `sync` == `filt`: `cnt` ← 0.
  - If `sync` != `filt` and `cnt` == `FilterCycles`-1: `filt` ← `sync`, `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt`+1.
  - Any single cycle where `sync` returns to `filt` discards the accumulated count. Glitches shorter than `FilterCycles` cycles at `sync` never reach `data_o`.
- Edges: `rise_o[c]` is high for exactly the first cycle in which `data_o[c]`=1 after being 0. `fall_o` is the mirror case. Both are registered and never high together for the same channel.
- Reset: all sync stages and `filt` load `ResetValue`; `cnt` loads 0; `rise_o` and `fall_o` load 0. Reset has priority over everything. A reset mid-filter discards progress.
- After reset release with `async_i` equal to `ResetValue`, no pulse is produced. If `async_i` differs from `ResetValue`, the normal transition and pulse occur after full latency.

## Timing
- Latency: if `async_i` is captured by stage 0 at edge k and held, `data_o`, `rise_o` and `fall_o` change after edge k+`SyncStages`+`FilterCycles`-1. With the defaults this is edge k+5.
- Sampling of a truly asynchronous edge adds 0–1 cycle of uncertainty.
- Throughput: a new transition can follow immediately. The minimum spacing of `data_o` transitions is `FilterCycles` cycles.
- Outputs are all flop-driven, with no combinational path from inputs to outputs.
- Sync stages carry the `ASYNC_REG` attribute. Stage 0 is the only flop with an asynchronous data input.

## Structure
- No shared package is needed. The counter width is a localparam.
- Sub-module `glitch_filter`: one instance per channel via generate. It contains `filt`, `cnt` and the edge registers, with ports `clk_i`, `rst_i`, `sync_i`, `level_o`, `rise_o`, `fall_o`, and parameters `FilterCycles` and `ResetValue`.
- The sync chain is a `Channels`-wide register array in the top level.

## Test plan
- **Reset values:** `ResetValue`=2'b01, `Channels`=2, reset held 3 cycles, `async_i`=2'b01 → `data_o`=01 and `rise_o`=`fall_o`=00 throughout and after release.
- **Latency:** defaults, `async_i` 0→1 captured at edge 10 → `data_o`=1 and `rise_o`=1 after edge 15; `rise_o`=0 after edge 16.
- **Glitch rejection:** `FilterCycles`=4, `async_i` pulsed high for 3 cycles → `data_o` stays 0 with no pulses. The same input held for 4 cycles → `data_o` rises.
- **Count restart:** `async_i` high 3 cycles, low 1 cycle, high 4 cycles → exactly one `rise_o`, occurring `SyncStages`+3 edges after the start of the second high period.
- **Mid-filter reset:** `rst_i` asserted 1 cycle while `cnt`=2 → `cnt`=0 and `data_o`=`ResetValue`. With input held, the transition occurs a full latency after release.
- **Channel independence:** `Channels`=4, `FilterCycles`=1, channel 2 toggles every 2 cycles while the other channels stay static → only bit 2 shows alternating `rise_o`/`fall_o`, with latency `SyncStages` edges.
